// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator.
// Decode and the hazard unit import the opcode encodings from here.
package pc_gen_pkg;

  typedef enum logic [3:0] {
    OP_J    = 4'd0,
    OP_JAL  = 4'd1,
    OP_BEQ  = 4'd2,
    OP_BNE  = 4'd3,
    OP_BGEZ = 4'd4,
    OP_BGTZ = 4'd5,
    OP_BLEZ = 4'd6,
    OP_BLTZ = 4'd7,
    OP_JR   = 4'd8,
    OP_JALR = 4'd9,
    OP_ADD4 = 4'd15
  } npc_op_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack: the oldest entry is overwritten when full,
// and popping an empty stack leaves the pointers untouched.
module ras_stack #(
  parameter int W         = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] pred,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(RAS_DEPTH);

  logic [W-1:0]  mem_q [RAS_DEPTH];
  logic [PW-1:0] sp_q, sp_d, sp_m1;
  logic [PW:0]   cnt_q, cnt_d;

  assign sp_m1 = sp_q - PW'(1);
  assign pred  = mem_q[sp_m1];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (PW+1)'(RAS_DEPTH));

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (en && push) begin
      sp_d = sp_q + PW'(1);
      if (!full) cnt_d = cnt_q + (PW+1)'(1);
    end else if (en && pop && !empty) begin
      sp_d  = sp_m1;
      cnt_d = cnt_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (!rst && en && push) mem_q[sp_q] <= wdata;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with full MIPS control-transfer resolution and a
// return-address stack that flags JR targets disagreeing with the prediction.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int             W         = 32,
  parameter logic [W-1:0]   RESET_PC  = W'(RESET_PC_DEFAULT),
  parameter int             RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic [3:0]   npc_op,
  input  logic [W-1:0] br_pc,
  input  logic [25:0]  instr_index,
  input  logic [W-1:0] imm_ext,
  input  logic [W-1:0] rs_val,
  input  logic [W-1:0] rt_val,
  output logic [W-1:0] pc,
  output logic [W-1:0] npc,
  output logic [W-1:0] link_addr,
  output logic         taken,
  output logic         ras_mispredict,
  output logic         ras_empty,
  output logic         ras_full
);

  logic [W-1:0] pc_q, pc_d;
  logic         misp_q, misp_d;
  logic [W-1:0] jump_tgt, branch_tgt, target;
  logic         push, pop;
  logic [W-1:0] ras_pred;

  assign link_addr  = br_pc + W'(4);
  assign jump_tgt   = {link_addr[W-1:28], instr_index, 2'b00};
  assign branch_tgt = link_addr + (imm_ext << 2);

  always_comb begin
    taken  = 1'b0;
    target = branch_tgt;
    case (npc_op)
      OP_J, OP_JAL:    begin taken = 1'b1; target = jump_tgt; end
      OP_JR, OP_JALR:  begin taken = 1'b1; target = rs_val;   end
      OP_BEQ:  taken = (rs_val == rt_val);
      OP_BNE:  taken = (rs_val != rt_val);
      OP_BGEZ: taken = ($signed(rs_val) >= 0);
      OP_BGTZ: taken = ($signed(rs_val) >  0);
      OP_BLEZ: taken = ($signed(rs_val) <= 0);
      OP_BLTZ: taken = ($signed(rs_val) <  0);
      default: taken = 1'b0;
    endcase
  end

  assign npc  = taken ? target : pc_q + W'(4);
  assign push = (npc_op == OP_JAL) || (npc_op == OP_JALR);
  assign pop  = (npc_op == OP_JR);

  ras_stack #(.W(W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk   (clk),
    .rst   (rst),
    .en    (!stall),
    .push  (push),
    .pop   (pop),
    .wdata (link_addr),
    .pred  (ras_pred),
    .empty (ras_empty),
    .full  (ras_full)
  );

  always_comb begin
    pc_d   = pc_q;
    misp_d = misp_q;
    if (!stall) begin
      pc_d   = npc;
      // An empty stack has no prediction, so any JR counts as a miss.
      misp_d = pop && (ras_empty || (ras_pred != rs_val));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      misp_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      misp_q <= misp_d;
    end
  end

  assign pc             = pc_q;
  assign ras_mispredict = misp_q;

endmodule

// File: doc/pc_gen.md
# pc_gen

Fetch-stage program-counter generator for the pipelined MIPS core: owns the PC register and resolves the full control-transfer set (J, JAL, JR, JALR, BEQ, BNE, BGEZ, BGTZ, BLEZ, BLTZ) from decode-stage operands. It adds stall hold, a parametrised reset vector, and a return-address stack (RAS) that flags JR targets which differ from the predicted return. It sits between the hazard unit/decode stage and the instruction memory address port.

## Interface
- `W`, 32: datapath/address width; must be ≥ 32.
- `RESET_PC`, 32'h0000_3000: PC value after reset.
- `RAS_DEPTH`, 4: RAS entries; power of two, ≥ 2.
- `clk`  in  1  rising-edge clock; the block uses this single clock.
- `rst`  in  1  reset; synchronous and active-high.
- `stall`  in  1  hazard-unit hold; PC and RAS are frozen while high.
- `npc_op`  in  4  control-transfer opcode of the instruction in decode.
- `br_pc`  in  W  PC of the instruction in decode.
- `instr_index`  in  26  J/JAL target field.
- `imm_ext`  in  W  sign-extended 16-bit offset, unshifted.
- `rs_val`, `rt_val`  in  W  forwarded register operands.
- `pc`  out  W  current fetch PC (register).
- `npc`  out  W  next PC (combinational).
- `link_addr`  out  W  `br_pc` + 4, written to $31/rd by JAL/JALR.
- `taken`  out  1  the decode instruction redirects fetch (combinational).
- `ras_mispredict`  out  1  registered one-cycle flag, raised when a JR target ≠ RAS prediction.
- `ras_empty`, `ras_full`  out  1  RAS occupancy flags.

## Operation
- Opcodes: JUMP=0, JAL=1, BEQ=2, BNE=3, BGEZ=4, BGTZ=5, BLEZ=6, BLTZ=7, JR=8, JALR=9, ADD4=15. Codes 10–14 behave as ADD4.
- Jump target: {(`br_pc`+4)[W-1:28], `instr_index`, 2'b00}.
- Branch target: `br_pc` + 4 + (`imm_ext` << 2).
- Register target: `rs_val`. All arithmetic is modulo 2^W.
- Branch conditions:
  - BEQ: rs == rt. BNE: rs ≠ rt.
  - BGEZ, BGTZ, BLEZ, BLTZ: signed comparison of rs against 0.
- `taken` = 1 for J/JAL/JR/JALR, for a branch whose condition holds, and 0 otherwise.
- `npc` = the selected target when `taken`, else `pc` + 4.
- RAS is a circular buffer with pointer `sp` and counter `cnt` (0..RAS_DEPTH). It updates only when `stall` = 0.
  - Push (JAL, JALR): write `link_addr` at `sp`, then `sp`+1. If already full, the oldest entry is overwritten and `cnt` stays at RAS_DEPTH.
  - Pop (JR): the prediction is the entry at `sp`−1. Then `sp`−1 and `cnt`−1.
  - Pop when empty: `sp` and `cnt` are unchanged, and the prediction is treated as a miss.
  - `ras_mispredict` <= (pop) & (empty | prediction ≠ `rs_val`). It is cleared on the next unstalled cycle.
- JR always jumps to `rs_val`. The RAS only flags the mismatch and never overrides the target.
- Flags: `ras_empty` = (`cnt` == 0); `ras_full` = (`cnt` == RAS_DEPTH).

## Timing
- `pc` <= `npc` on each rising edge where `stall` = 0. When `stall` = 1, `pc`, `sp`, `cnt` and `ras_mispredict` hold.
- Redirect latency: a taken instruction in decode during cycle n makes `pc` = target in cycle n+1. There is no delay slot; wrong-path fetch flush belongs to the hazard unit.
- `rst` takes priority over `stall`. On the next edge: `pc`=RESET_PC, `sp`=0, `cnt`=0, `ras_mispredict`=0, and RAS contents are don't-care.
- Outputs during reset:
  - `npc` and `taken` remain combinational from the inputs.
  - `ras_empty`=1 and `ras_full`=0 from the first post-reset cycle.
- Reset mid-operation discards RAS contents. A JR after reset with an empty RAS raises `ras_mispredict`.

## Structure
- Shared package `pc_gen_pkg` holds the `npc_op` encodings and the RESET_PC default. Decode and the hazard unit import it.
- One sub-module, `ras_stack`, is natural. It takes `clk`/`rst`/push/pop/wdata and exposes prediction/empty/full, parametrised by `W` and `RAS_DEPTH`.
- Target muxing and branch compare stay in `pc_gen`.

## Test plan
- Reset then 3 unstalled cycles with ADD4 → `pc` = 0x3000, 0x3004, 0x3008, 0x300C; `ras_empty`=1.
- BEQ, `br_pc`=0x3010, imm_ext=0xFFFF_FFFE, rs=rt=5 → `taken`=1, next `pc`=0x300C. With rt=6 → `taken`=0, `pc`+4.
- BGEZ/BLTZ/BGTZ/BLEZ with rs = 0, 1, 0x8000_0000:
  - BGEZ taken for {0, 1}.
  - BLTZ taken for {0x8000_0000}.
  - BGTZ taken for {1}.
  - BLEZ taken for {0, 0x8000_0000}.
- JAL at `br_pc`=0x3020, index=0x0000100 → `pc`=0x0000_0400, `link_addr`=0x3024 pushed. JR rs=0x3024 → `pc`=0x3024, `ras_mispredict`=0. JR rs=0x3028 (after another JAL) → `ras_mispredict`=1 for one cycle.
- 5 JALs with RAS_DEPTH=4 → `ras_full`=1. The following 4 JRs match the last 4 links. A 5th JR → empty miss, `ras_mispredict`=1.
- `stall`=1 held 3 cycles with JAL in decode → `pc`, `cnt` unchanged. `rst` asserted while stalled → `pc`=0x3000 next edge.
